memory: RTL and testbench

//  Single-port synchronous RAM, WIDTH x DEPTH, with a valid/ready request handshake.
//  One request per cycle: write (wr_rd=1) or read (wr_rd=0).

---
 rtl/memory.sv | 85 ++++++++
 tb/tb_memory.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory
//   Single-port synchronous RAM (WIDTH x DEPTH) behind a valid/ready request
//   handshake. One request per cycle: a write (wr_rd=1) or a read (wr_rd=0).
//   A request is accepted on a rising clock edge when valid and ready are both
//   high. Reads have one cycle of latency, and rdata holds its value until the
//   next accepted read. The storage array is named `mem` so that a testbench
//   can load or dump it directly.
//
// Ports
//   clk    in   1           clock; all state updates on the rising edge
//   rst    in   1           asynchronous reset, active low (0 = in reset)
//   wr_rd  in   1           request type: 1 = write, 0 = read
//   addr   in   ADDR_WIDTH  word address
//   wdata  in   WIDTH       write data
//   valid  in   1           request valid
//   ready  out  1           request can be accepted this cycle
//   rdata  out  WIDTH       registered read data
// ---------------------------------------------------------------------------
module memory #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_rd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  valid,
   output logic                  ready,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   logic accept;
   logic in_range;

   assign accept = valid & ready;

   // A power-of-two depth covers the whole address space, so every address
   // is valid. Otherwise, addresses past the last word are treated as holes:
   // writes to them are dropped and reads from them return zero.
   generate
      if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
         assign in_range = 1'b1;
      end else begin : g_partial_range
         localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
         assign in_range = ({1'b0, addr} < DEPTH_W);
      end
   endgenerate

   // ready rises on the first edge after reset is released and then stays
   // high. There is no back-pressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready <= 1'b0;
      end else begin
         ready <= 1'b1;
      end
   end

   // Registered read port. It updates only on an accepted read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (accept && !wr_rd) begin
         rdata <= in_range ? mem[addr] : '0;
      end
   end

   // Storage. Reset clears every word. A reset that arrives before the edge
   // of an in-flight write wins, so the write never lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (accept && wr_rd && in_range) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: tb/tb_memory.sv
// ---------------------------------------------------------------------------
// tb_memory
//   Self-checking bench for memory. The reference model is a plain array plus
//   the last read value and the expected ready level. It is updated from the
//   handshake rules at each rising edge. Outputs are sampled on the falling
//   edge, and the storage is inspected through the hierarchy as dut.mem.
// ---------------------------------------------------------------------------
module tb_memory;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk;
   logic             rst;
   logic             wr_rd;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] wdata;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] rdata;

   memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .wr_rd (wr_rd),
      .addr  (addr),
      .wdata (wdata),
      .valid (valid),
      .ready (ready),
      .rdata (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model
   logic [WIDTH-1:0] ref_mem [DEPTH];
   logic [WIDTH-1:0] ref_rd;
   bit               ref_ready;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_rd    = '0;
      ref_ready = 1'b0;
   endtask

   // Drive one request for one cycle. The model acts at the rising edge using
   // the ready level that held before that edge. Outputs are then checked on
   // the following falling edge.
   task automatic step(input bit v, input bit w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      valid = v;
      wr_rd = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      if (v && ref_ready) begin
         if (w) ref_mem[a] = d;
         else   ref_rd = ref_mem[a];
      end
      ref_ready = rst;
      @(negedge clk);
      check("rdata", 32'(rdata), 32'(ref_rd));
      check("ready", 32'(ready), 32'(ref_ready));
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         check(tag, 32'(dut.mem[i]), 32'(ref_mem[i]));
      end
   endtask

   // Assert reset partway through a low clock phase while a write is
   // presented. The effect must be immediate, and the write must be lost.
   task automatic mid_reset(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      valid = 1'b1;
      wr_rd = 1'b1;
      addr  = a;
      wdata = d;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("rst_ready", 32'(ready), 32'(0));
      check("rst_rdata", 32'(rdata), 32'(0));
      check_mem("rst_mem");
      @(posedge clk);
      @(negedge clk);
      check_mem("rst_mem_hold");
      valid = 1'b0;
      rst   = 1'b1;
   endtask

   logic [WIDTH-1:0] vals [5];
   logic [AW-1:0]    a4;

   initial begin
      valid = 1'b0;
      wr_rd = 1'b0;
      addr  = '0;
      wdata = '0;
      rst   = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      #2;
      check("init_ready", 32'(ready), 32'(0));
      check("init_rdata", 32'(rdata), 32'(0));
      check_mem("init_mem");

      // Requests presented during reset are ignored
      @(negedge clk);
      step(1'b1, 1'b1, 4'd3, 8'h77);
      check_mem("in_reset_mem");
      rst = 1'b1;

      // The first edge after release raises ready and accepts nothing
      step(1'b1, 1'b1, 4'd4, 8'h11);
      check_mem("release_mem");

      // Single write and read at the top address
      step(1'b1, 1'b1, 4'd15, 8'hA5);
      step(1'b1, 1'b0, 4'd15, 8'h00);
      check("rd15", 32'(rdata), 32'hA5);

      // Five writes starting at 15 wrap to 0..3, then read back in order
      for (int i = 0; i < 5; i++) begin
         vals[i] = 8'($urandom);
         a4 = 4'(15 + i);
         step(1'b1, 1'b1, a4, vals[i]);
      end
      for (int i = 0; i < 5; i++) begin
         a4 = 4'(15 + i);
         step(1'b1, 1'b0, a4, 8'h00);
         check("wrap_rd", 32'(rdata), 32'(vals[i]));
      end

      // Full sweep with values in the range 100..200
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b1, 4'(i), 8'($urandom_range(200, 100)));
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 4'(i), 8'h00);
      end
      check_mem("sweep_mem");

      // Idle cycles with garbage on the request fields change nothing
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
      end
      check_mem("idle_mem");

      // Random mixed traffic, including back-to-back write then read
      for (int i = 0; i < 300; i++) begin
         a4 = 4'($urandom);
         if (($urandom % 4) == 0) begin
            step(1'b1, 1'b1, a4, 8'($urandom));
            step(1'b1, 1'b0, a4, 8'($urandom));
         end else begin
            step(1'($urandom_range(3, 0) != 0), 1'($urandom), a4, 8'($urandom));
         end
      end
      check_mem("rand_mem");

      // Reset in the middle of traffic
      @(negedge clk);
      mid_reset(4'd9, 8'h5C);
      step(1'b1, 1'b1, 4'd9, 8'h66);
      check_mem("post_rst_mem");

      // Front-door writes to 5..14 only. All other words must still read 0.
      for (int i = 5; i <= 14; i++) begin
         step(1'b1, 1'b1, 4'(i), 8'($urandom_range(255, 1)));
      end
      check_mem("front_write_mem");
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 4'(i), 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
